// File: rtl/counter_run_ctrl.sv
// Run controller: loads a start count, counts up to a limit, then stops
// or reloads, with pause/abort control and a saturating pass counter.
module counter_run_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              auto_reload,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] passes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count;
  logic [WIDTH-1:0]   r_limit;
  logic [WIDTH-1:0]   w_limit;
  logic [WIDTH-1:0]   r_load;
  logic [WIDTH-1:0]   w_load;
  logic               r_reload;
  logic               w_reload;
  logic               r_done;
  logic               w_done;
  logic [PASS_W-1:0]  r_passes;
  logic [PASS_W-1:0]  w_passes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_limit  <= '0;
      r_load   <= '0;
      r_reload <= 1'b0;
      r_done   <= 1'b0;
      r_passes <= '0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_limit  <= w_limit;
      r_load   <= w_load;
      r_reload <= w_reload;
      r_done   <= w_done;
      r_passes <= w_passes;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_limit  = r_limit;
    w_load   = r_load;
    w_reload = r_reload;
    w_done   = 1'b0;
    w_passes = r_passes;
    unique case (r_state)
      IDLE, DONE: begin
        // start outranks stop when both arrive together
        if (start) begin
          w_count  = load_val;
          w_limit  = limit;
          w_load   = load_val;
          w_reload = auto_reload;
          w_passes = '0;
          w_state  = RUN;
        end else if (stop) begin
          w_state  = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          w_state = IDLE;
        end else if (pause) begin
          w_state = PAUSE;
        end else if (r_count == r_limit) begin
          w_done   = 1'b1;
          w_passes = (r_passes == '1) ? r_passes
                                      : r_passes + 1'b1;
          if (r_reload) begin
            w_count = r_load;
          end else begin
            w_state = DONE;
          end
        end else begin
          w_count = r_count + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          w_state = IDLE;
        end else if (!pause) begin
          w_state = RUN;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign count  = r_count;
  assign busy   = (r_state == RUN) || (r_state == PAUSE);
  assign done   = r_done;
  assign passes = r_passes;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with hand-computed expectations.
module tb_counter_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [7:0] passes;

  int n_cmp;
  int n_err;

  counter_run_ctrl #(.WIDTH(4), .PASS_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .limit       (limit),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .passes      (passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] ld,
                    input logic [3:0] lm,
                    input logic ar);
    load_val    = ld;
    limit       = lm;
    auto_reload = ar;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  logic [3:0] wrap_exp [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    auto_reload = 1'b0;
    load_val = 4'd0;
    limit = 4'd0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_passes", passes, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_hold_busy", busy, 0);

    // single run 0..3
    go(4'd0, 4'd3, 1'b0);
    chk("s_e0_count", count, 0);
    chk("s_e0_busy", busy, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("s_count", count, k);
      chk("s_nodone", done, 0);
    end
    tick();
    chk("s_done", done, 1);
    chk("s_busy_fall", busy, 0);
    chk("s_count_end", count, 3);
    chk("s_passes", passes, 1);
    tick();
    chk("s_done_1cyc", done, 0);
    chk("s_hold_count", count, 3);
    chk("s_hold_passes", passes, 1);

    // pause three cycles at count 1
    go(4'd0, 4'd3, 1'b0);
    chk("p_passes_clr", passes, 0);
    tick();
    chk("p_e1", count, 1);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p_hold", count, 1);
      chk("p_busy", busy, 1);
    end
    pause = 1'b0;
    tick();
    chk("p_resume", count, 1);
    tick();
    chk("p_e6", count, 2);
    tick();
    chk("p_e7", count, 3);
    chk("p_e7_nodone", done, 0);
    tick();
    chk("p_e8_done", done, 1);

    // wrap 14 -> 1
    wrap_exp[0] = 4'd14;
    wrap_exp[1] = 4'd15;
    wrap_exp[2] = 4'd0;
    wrap_exp[3] = 4'd1;
    go(4'd14, 4'd1, 1'b0);
    chk("w_e0", count, wrap_exp[0]);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("w_count", count, wrap_exp[k]);
      chk("w_nodone", done, 0);
    end
    tick();
    chk("w_done", done, 1);
    chk("w_end", count, 1);

    // auto-reload 2..4, with an ignored start at edge 4
    go(4'd2, 4'd4, 1'b1);
    chk("a_e0", count, 2);
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) begin
        start       = 1'b1;
        limit       = 4'd7;
        load_val    = 4'd0;
        auto_reload = 1'b0;
      end
      tick();
      start = 1'b0;
      chk("a_count", count, 2 + (k % 3));
      chk("a_done", done, (k % 3 == 0) ? 1 : 0);
      chk("a_busy", busy, 1);
    end
    chk("a_passes", passes, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("a_stop_busy", busy, 0);
    chk("a_stop_count", count, 2);
    chk("a_stop_done", done, 0);
    tick();
    chk("a_idle_busy", busy, 0);

    // reset mid-run
    go(4'd0, 4'd3, 1'b0);
    tick();
    tick();
    chk("r_pre", count, 2);
    rst_n = 1'b0;
    #1;
    chk("r_count", count, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_ign_busy", busy, 0);
      chk("r_ign_done", done, 0);
      chk("r_ign_count", count, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("r_idle", busy, 0);
    go(4'd1, 4'd2, 1'b0);
    chk("r_new_e0", count, 1);
    tick();
    chk("r_new_e1", count, 2);
    tick();
    chk("r_new_done", done, 1);
    chk("r_new_passes", passes, 1);

    // start and stop together in DONE
    load_val = 4'd5;
    limit = 4'd6;
    auto_reload = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 1);
    chk("ss_count", count, 5);
    chk("ss_passes", passes, 0);
    tick();
    chk("ss_e1", count, 6);
    tick();
    chk("ss_done", done, 1);

    // stop in DONE returns to IDLE without side effects
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sd_busy", busy, 0);
    chk("sd_count", count, 6);
    chk("sd_passes", passes, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
